spi2wb: RTL

//  SPI slave (mode 0, MSB first) that acts as a Wishbone master: the far-end responder for the
//  SPI master in the AHB->WB->SPI bridge. An external SPI master sends a 2-byte frame
//  (command, data); the block runs one Wishbone write or read per frame. sck/ss_n/mosi are

---
 rtl/spi2wb.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/spi2wb.sv
// SPI mode-0 slave that turns each 2-byte frame (command, data) into one Wishbone access.
// sck/ss_n/mosi are oversampled in the wb_clk domain.
module spi2wb #(
   parameter int unsigned ADDR_WIDTH  = 2,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  wb_clk,
   input  logic                  wb_rst,
   input  logic                  sck,
   input  logic                  ss_n,
   input  logic                  mosi,
   output logic                  miso,
   output logic                  wb_cyc,
   output logic                  wb_stb,
   output logic [ADDR_WIDTH-1:0] wb_addr,
   output logic                  wb_we,
   output logic [7:0]            wb_data_out,
   input  logic [7:0]            wb_data_in,
   input  logic                  wb_ack,
   output logic                  rd_late
);

   typedef enum logic [2:0] {StIdle, StCmd, StRdReq, StData, StWrReq, StDone} state_e;

   logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
   logic                   sck_s, ss_s, mosi_s, sck_prev_q, ss_prev_q;
   logic                   sck_rise, sck_fall, ss_rise, ss_fall, shift_in;
   state_e                 state_q, state_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [6:0]             rx_sr_q, rx_sr_d;
   logic [7:0]             rx_byte, tx_sr_q, tx_sr_d, wdata_q, wdata_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic                   we_q, we_d, late_q, late_d, abort_q, abort_d;
   logic                   pend_q, pend_d, rd_late_q, rd_late_d;

   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign ss_s     = ss_sync_q[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s & sck_prev_q;
   assign ss_rise  = ss_s & ~ss_prev_q;
   assign ss_fall  = ~ss_s & ss_prev_q;
   assign rx_byte  = {rx_sr_q, mosi_s};
   // Rises seen while the read is still outstanding belong to byte 2 and must be counted.
   assign shift_in = sck_rise & ~abort_q &
                     (state_q == StCmd || state_q == StRdReq || state_q == StData);

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         sck_sync_q  <= '0;
         ss_sync_q   <= '0;
         mosi_sync_q <= '0;
         sck_prev_q  <= 1'b0;
         ss_prev_q   <= 1'b0;
         state_q     <= StIdle;
         bit_cnt_q   <= 3'd0;
         rx_sr_q     <= 7'd0;
         tx_sr_q     <= 8'd0;
         wdata_q     <= 8'd0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         late_q      <= 1'b0;
         abort_q     <= 1'b0;
         pend_q      <= 1'b0;
         rd_late_q   <= 1'b0;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
         sck_prev_q  <= sck_s;
         ss_prev_q   <= ss_s;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_sr_q     <= rx_sr_d;
         tx_sr_q     <= tx_sr_d;
         wdata_q     <= wdata_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         late_q      <= late_d;
         abort_q     <= abort_d;
         pend_q      <= pend_d;
         rd_late_q   <= rd_late_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      rx_sr_d   = rx_sr_q;
      tx_sr_d   = tx_sr_q;
      wdata_d   = wdata_q;
      addr_d    = addr_q;
      we_d      = we_q;
      late_d    = late_q;
      abort_d   = abort_q;
      pend_d    = pend_q;
      rd_late_d = 1'b0;

      if (shift_in) begin
         rx_sr_d   = rx_byte[6:0];
         bit_cnt_d = bit_cnt_q + 3'd1;
      end
      if (ss_rise) begin
         bit_cnt_d = 3'd0;
         pend_d    = 1'b0;
      end
      // A frame that opens while a WB cycle is still draining starts once we are back in idle.
      if (ss_fall && state_q != StIdle) pend_d = 1'b1;

      unique case (state_q)
         StIdle: begin
            if (ss_fall || pend_q) begin
               state_d   = StCmd;
               bit_cnt_d = 3'd0;
               rx_sr_d   = 7'd0;
               tx_sr_d   = 8'd0;
               late_d    = 1'b0;
               abort_d   = 1'b0;
               pend_d    = 1'b0;
            end
         end
         StCmd: begin
            if (ss_rise) begin
               state_d = StIdle;
            end else if (shift_in && bit_cnt_q == 3'd7) begin
               we_d    = rx_byte[7];
               addr_d  = rx_byte[ADDR_WIDTH-1:0];
               state_d = rx_byte[7] ? StData : StRdReq;
            end
         end
         StRdReq: begin
            if (ss_rise) abort_d = 1'b1;
            if (shift_in && bit_cnt_q == 3'd0 && !late_q) begin
               late_d    = 1'b1;
               rd_late_d = 1'b1;
            end
            if (wb_ack) begin
               if (abort_q || ss_rise) begin
                  state_d = StIdle;
               end else begin
                  state_d = StData;
                  if (!late_d) tx_sr_d = wb_data_in;
               end
            end
         end
         StData: begin
            if (ss_rise) begin
               state_d = StIdle;
            end else begin
               // bit_cnt is 0 on the fall after the 8th command bit, so that fall never shifts.
               if (sck_fall && bit_cnt_q != 3'd0) tx_sr_d = {tx_sr_q[6:0], 1'b0};
               if (shift_in && bit_cnt_q == 3'd7) begin
                  if (we_q) begin
                     wdata_d = rx_byte;
                     state_d = StWrReq;
                  end else begin
                     state_d = StDone;
                  end
               end
            end
         end
         StWrReq: begin
            if (ss_rise) abort_d = 1'b1;
            if (wb_ack) state_d = (abort_q || ss_rise) ? StIdle : StDone;
         end
         StDone: begin
            if (ss_rise) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign wb_cyc      = (state_q == StRdReq) || (state_q == StWrReq);
   assign wb_stb      = wb_cyc;
   assign wb_we       = (state_q == StWrReq);
   assign wb_addr     = addr_q;
   assign wb_data_out = wdata_q;
   assign rd_late     = rd_late_q;
   assign miso        = (state_q == StData) & ~ss_s & tx_sr_q[7];

endmodule
